// File: rtl/bullet_ctrl.sv
// Bullet slot manager for two shooters: fire arbitration, per-frame motion, retire/kill,
// and a registered per-pixel sprite lookup feeding the bullet ROM.

module bullet_slot #(
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int SPEED = 4,
   parameter int Y_MAX = 479
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           alloc,
   input  logic           own_in,
   input  logic [X_W-1:0] x_in,
   input  logic [Y_W-1:0] y_in,
   input  logic           kill,
   input  logic           tick,
   input  logic [X_W-1:0] pix_x,
   input  logic [Y_W-1:0] pix_y,
   output logic           act,
   output logic           own,
   output logic           hit,
   output logic [2:0]     dx,
   output logic [2:0]     dy
);
   localparam logic [Y_W:0]   SPD  = (Y_W+1)'(SPEED);
   localparam logic [Y_W:0]   LIM  = (Y_W+1)'(Y_MAX - 5);
   localparam logic [X_W-1:0] X5   = X_W'(5);
   localparam logic [Y_W-1:0] Y5   = Y_W'(5);

   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [Y_W:0]   y_up;
   logic [X_W-1:0] ox;
   logic [Y_W-1:0] oy;

   assign y_up = {1'b0, y} + SPD;

   always_ff @(posedge clk) begin
      if (rst) begin
         act <= 1'b0;
         own <= 1'b0;
         x   <= '0;
         y   <= '0;
      end else if (alloc) begin
         act <= 1'b1;
         own <= own_in;
         x   <= x_in;
         y   <= y_in;
      end else if (act && kill) begin
         act <= 1'b0;
      end else if (act && tick) begin
         // owner 0 travels up the screen, owner 1 down; leaving the visible area retires
         if (!own) begin
            if ({1'b0, y} < SPD) act <= 1'b0;
            else                 y   <= y - SPD[Y_W-1:0];
         end else begin
            if (y_up > LIM) act <= 1'b0;
            else            y   <= y_up[Y_W-1:0];
         end
      end
   end

   // modular subtract: a pixel left of/above the sprite wraps large and never hits
   assign ox  = pix_x - x;
   assign oy  = pix_y - y;
   assign hit = act && (ox <= X5) && (oy <= Y5);
   assign dx  = ox[2:0];
   assign dy  = oy[2:0];
endmodule

module bullet_ctrl #(
   parameter int N_BUL = 4,
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int SPEED = 4,
   parameter int Y_MAX = 479
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic [1:0]       fire_req,
   input  logic [X_W-1:0]   fire_x0,
   input  logic [Y_W-1:0]   fire_y0,
   input  logic [X_W-1:0]   fire_x1,
   input  logic [Y_W-1:0]   fire_y1,
   output logic [1:0]       fire_ack,
   input  logic [N_BUL-1:0] kill,
   input  logic [X_W-1:0]   pix_x,
   input  logic [Y_W-1:0]   pix_y,
   output logic [2:0]       spr_x,
   output logic [2:0]       spr_y,
   output logic             spr_en,
   output logic             spr_owner,
   output logic [N_BUL-1:0] active
);
   logic [N_BUL-1:0]      hit, own, free, alloc_oh, alloc;
   logic [N_BUL-1:0][2:0] dxs, dys;
   logic [1:0]            elig, gnt;
   logic                  rr;
   logic [X_W-1:0]        nx;
   logic [Y_W-1:0]        ny;
   logic                  en_d, so_d;
   logic [2:0]            sx_d, sy_d;

   always_comb begin
      elig     = fire_req & ~fire_ack;
      free     = ~active;
      alloc_oh = free & (~free + N_BUL'(1));
      gnt      = 2'b00;
      if (|free) begin
         if (elig == 2'b11) gnt = rr ? 2'b10 : 2'b01;
         else               gnt = elig;
      end
      alloc = (|gnt) ? alloc_oh : '0;
      nx    = gnt[1] ? fire_x1 : fire_x0;
      ny    = gnt[1] ? fire_y1 : fire_y0;
      en_d  = 1'b0;
      so_d  = 1'b0;
      sx_d  = 3'd0;
      sy_d  = 3'd0;
      for (int k = N_BUL-1; k >= 0; k--) begin
         if (hit[k]) begin
            en_d = 1'b1;
            so_d = own[k];
            sx_d = dxs[k];
            sy_d = dys[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fire_ack  <= 2'b00;
         rr        <= 1'b0;
         spr_en    <= 1'b0;
         spr_owner <= 1'b0;
         spr_x     <= 3'd0;
         spr_y     <= 3'd0;
      end else begin
         fire_ack <= gnt;
         // pointer names the shooter that wins the next tie: the one not just served
         if (|gnt) rr <= gnt[0];
         spr_en    <= en_d;
         spr_owner <= so_d;
         spr_x     <= sx_d;
         spr_y     <= sy_d;
      end
   end

   for (genvar g = 0; g < N_BUL; g++) begin : g_slot
      bullet_slot #(.X_W(X_W), .Y_W(Y_W), .SPEED(SPEED), .Y_MAX(Y_MAX)) u_slot (
         .clk    (clk),
         .rst    (rst),
         .alloc  (alloc[g]),
         .own_in (gnt[1]),
         .x_in   (nx),
         .y_in   (ny),
         .kill   (kill[g]),
         .tick   (frame_tick),
         .pix_x  (pix_x),
         .pix_y  (pix_y),
         .act    (active[g]),
         .own    (own[g]),
         .hit    (hit[g]),
         .dx     (dxs[g]),
         .dy     (dys[g])
      );
   end
endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: hand-computed vector table, multi-cycle corner sequences,
// then random traffic against a slot-list reference model.

module tb_bullet_ctrl;
   localparam int N = 4, SPD = 4, YMAX = 479, XM = 1023, YM = 1023;

   logic         clk = 1'b0;
   logic         rst = 1'b1, frame_tick = 1'b0;
   logic [1:0]   fire_req = 2'b00, fire_ack;
   logic [9:0]   fire_x0 = '0, fire_y0 = '0, fire_x1 = '0, fire_y1 = '0;
   logic [N-1:0] kill = '0, active;
   logic [9:0]   pix_x = '0, pix_y = '0;
   logic [2:0]   spr_x, spr_y;
   logic         spr_en, spr_owner;

   int total = 0, bad = 0;

   bullet_ctrl #(.N_BUL(N), .X_W(10), .Y_W(10), .SPEED(SPD), .Y_MAX(YMAX)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire_req(fire_req),
      .fire_x0(fire_x0), .fire_y0(fire_y0), .fire_x1(fire_x1), .fire_y1(fire_y1),
      .fire_ack(fire_ack), .kill(kill), .pix_x(pix_x), .pix_y(pix_y),
      .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_owner(spr_owner), .active(active)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // reference model: a list of slots with plain integer fields
   bit m_act[N], n_act[N];
   int m_own[N], m_x[N], m_y[N], n_own[N], n_x[N], n_y[N];
   int m_rr = 0, m_ack = 0, m_en = 0, m_sx = 0, m_sy = 0, m_so = 0;
   int n_rr, n_ack, n_en, n_sx, n_sy, n_so;

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic mdl_eval();
      int win, fs, ox, oy;
      bit e0, e1;
      n_en = 0; n_sx = 0; n_sy = 0; n_so = 0; n_ack = 0; n_rr = m_rr;
      for (int k = 0; k < N; k++) begin
         n_act[k] = m_act[k]; n_own[k] = m_own[k]; n_x[k] = m_x[k]; n_y[k] = m_y[k];
      end
      if (rst) begin
         n_rr = 0;
         for (int k = 0; k < N; k++) begin
            n_act[k] = 0; n_own[k] = 0; n_x[k] = 0; n_y[k] = 0;
         end
      end else begin
         for (int k = N-1; k >= 0; k--) begin
            ox = (int'(pix_x) - m_x[k]) & XM;
            oy = (int'(pix_y) - m_y[k]) & YM;
            if (m_act[k] && ox <= 5 && oy <= 5) begin
               n_en = 1; n_sx = ox; n_sy = oy; n_so = m_own[k];
            end
         end
         for (int k = 0; k < N; k++) begin
            if (m_act[k]) begin
               if (kill[k]) n_act[k] = 0;
               else if (frame_tick) begin
                  if (m_own[k] == 0) begin
                     if (m_y[k] < SPD) n_act[k] = 0; else n_y[k] = m_y[k] - SPD;
                  end else begin
                     if (m_y[k] + SPD > YMAX - 5) n_act[k] = 0; else n_y[k] = m_y[k] + SPD;
                  end
               end
            end
         end
         e0 = fire_req[0] && !m_ack[0];
         e1 = fire_req[1] && !m_ack[1];
         win = -1;
         if (e0 && e1) win = m_rr;
         else if (e0)  win = 0;
         else if (e1)  win = 1;
         fs = -1;
         for (int k = N-1; k >= 0; k--) if (!m_act[k]) fs = k;
         if (win >= 0 && fs >= 0) begin
            n_act[fs] = 1;
            n_own[fs] = win;
            n_x[fs]   = win ? int'(fire_x1) : int'(fire_x0);
            n_y[fs]   = win ? int'(fire_y1) : int'(fire_y0);
            n_ack     = 1 << win;
            n_rr      = 1 - win;
         end
      end
   endtask

   task automatic cyc();
      int a;
      mdl_eval();
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         m_act[k] = n_act[k]; m_own[k] = n_own[k]; m_x[k] = n_x[k]; m_y[k] = n_y[k];
      end
      m_rr = n_rr; m_ack = n_ack; m_en = n_en; m_sx = n_sx; m_sy = n_sy; m_so = n_so;
      a = 0;
      for (int k = 0; k < N; k++) if (m_act[k]) a |= (1 << k);
      chk("mdl_ack", int'(fire_ack), m_ack);
      chk("mdl_active", int'(active), a);
      chk("mdl_en", int'(spr_en), m_en);
      chk("mdl_sx", int'(spr_x), m_sx);
      chk("mdl_sy", int'(spr_y), m_sy);
      chk("mdl_owner", int'(spr_owner), m_so);
   endtask

   task automatic drive(input bit r, input bit t, input logic [1:0] req,
                        input logic [N-1:0] kl, input int px, input int py);
      rst = r; frame_tick = t; fire_req = req; kill = kl;
      pix_x = 10'(px); pix_y = 10'(py);
   endtask

   typedef struct {
      bit r; bit t; logic [1:0] req; logic [N-1:0] kl; int px; int py;
      int ack; int act; int en; int sx; int sy; int so;
   } vec_t;

   vec_t tv[18];

   initial begin
      tv[0]  = '{1, 0, 2'b00, 4'b0000,   0,   0,  0,  0, 0, 0, 0, 0};
      tv[1]  = '{0, 0, 2'b01, 4'b0000,   0,   0,  1,  1, 0, 0, 0, 0};
      tv[2]  = '{0, 0, 2'b00, 4'b0000, 103, 405,  0,  1, 1, 3, 5, 0};
      tv[3]  = '{0, 0, 2'b00, 4'b0000,  99, 400,  0,  1, 0, 0, 0, 0};
      tv[4]  = '{0, 0, 2'b00, 4'b0000, 105, 400,  0,  1, 1, 5, 0, 0};
      tv[5]  = '{0, 0, 2'b00, 4'b0000, 100, 406,  0,  1, 0, 0, 0, 0};
      tv[6]  = '{1, 0, 2'b00, 4'b0000,   0,   0,  0,  0, 0, 0, 0, 0};
      tv[7]  = '{0, 0, 2'b11, 4'b0000,   0,   0,  1,  1, 0, 0, 0, 0};
      tv[8]  = '{0, 0, 2'b11, 4'b0000,   0,   0,  2,  3, 0, 0, 0, 0};
      tv[9]  = '{0, 0, 2'b11, 4'b0000,   0,   0,  1,  7, 0, 0, 0, 0};
      tv[10] = '{0, 0, 2'b11, 4'b0000,   0,   0,  2, 15, 0, 0, 0, 0};
      tv[11] = '{0, 0, 2'b11, 4'b0000,   0,   0,  0, 15, 0, 0, 0, 0};
      tv[12] = '{0, 0, 2'b11, 4'b0000,   0,   0,  0, 15, 0, 0, 0, 0};
      tv[13] = '{0, 1, 2'b11, 4'b0010,   0,   0,  0, 13, 0, 0, 0, 0};
      tv[14] = '{0, 0, 2'b00, 4'b0000, 100, 396,  0, 13, 1, 0, 0, 0};
      tv[15] = '{0, 0, 2'b00, 4'b0000, 202,  55,  0, 13, 1, 2, 1, 1};
      tv[16] = '{0, 0, 2'b10, 4'b0000,   0,   0,  2, 15, 0, 0, 0, 0};
      tv[17] = '{0, 0, 2'b00, 4'b0000, 202,  55,  0, 15, 1, 2, 5, 1};

      fire_x0 = 10'd100; fire_y0 = 10'd400; fire_x1 = 10'd200; fire_y1 = 10'd50;
      for (int i = 0; i < 18; i++) begin
         drive(tv[i].r, tv[i].t, tv[i].req, tv[i].kl, tv[i].px, tv[i].py);
         cyc();
         chk($sformatf("tbl%0d_ack", i), int'(fire_ack), tv[i].ack);
         chk($sformatf("tbl%0d_active", i), int'(active), tv[i].act);
         chk($sformatf("tbl%0d_en", i), int'(spr_en), tv[i].en);
         chk($sformatf("tbl%0d_sx", i), int'(spr_x), tv[i].sx);
         chk($sformatf("tbl%0d_sy", i), int'(spr_y), tv[i].sy);
         chk($sformatf("tbl%0d_owner", i), int'(spr_owner), tv[i].so);
      end

      // owner 0 near the top: one move to y=2, then retired; slot reusable afterwards
      fire_x0 = 10'd10; fire_y0 = 10'd6;
      drive(1, 0, 2'b00, 0, 0, 0); cyc();
      drive(0, 0, 2'b01, 0, 0, 0); cyc(); chk("up_spawn", int'(active), 1);
      drive(0, 1, 2'b00, 0, 0, 0); cyc(); chk("up_move_live", int'(active), 1);
      drive(0, 0, 2'b00, 0, 10, 2); cyc(); chk("up_at_y2", int'(spr_en), 1);
      drive(0, 1, 2'b00, 0, 0, 0); cyc(); chk("up_retired", int'(active), 0);
      drive(0, 0, 2'b01, 0, 0, 0); cyc(); chk("up_reuse_ack", int'(fire_ack), 1);
      chk("up_reuse_act", int'(active), 1);

      // owner 1 near the bottom: 470 -> 474 stays, next tick retires
      fire_x1 = 10'd300; fire_y1 = 10'd470;
      drive(1, 0, 2'b00, 0, 0, 0); cyc();
      drive(0, 0, 2'b10, 0, 0, 0); cyc(); chk("dn_spawn_ack", int'(fire_ack), 2);
      drive(0, 1, 2'b00, 0, 0, 0); cyc(); chk("dn_474_live", int'(active), 1);
      drive(0, 0, 2'b00, 0, 300, 479); cyc(); chk("dn_474_sy", int'(spr_y), 5);
      chk("dn_474_owner", int'(spr_owner), 1);
      drive(0, 1, 2'b00, 0, 0, 0); cyc(); chk("dn_retired", int'(active), 0);

      // reset mid-operation overrides fire, tick, kill and a pixel hit; pointer back to 0
      fire_x0 = 10'd100; fire_y0 = 10'd400;
      drive(0, 0, 2'b01, 0, 0, 0); cyc();
      drive(0, 0, 2'b00, 0, 0, 0); cyc();
      drive(1, 1, 2'b11, 4'b1111, 100, 400); cyc();
      chk("mrst_ack", int'(fire_ack), 0);
      chk("mrst_active", int'(active), 0);
      chk("mrst_en", int'(spr_en), 0);
      drive(0, 0, 2'b11, 0, 0, 0); cyc(); chk("mrst_rr", int'(fire_ack), 1);

      // random traffic against the model
      drive(1, 0, 2'b00, 0, 0, 0); cyc();
      for (int i = 0; i < 1500; i++) begin
         int k;
         logic [N-1:0] kl;
         kl = '0;
         for (int j = 0; j < N; j++) if ($urandom_range(0, 9) == 0) kl[j] = 1'b1;
         fire_x0 = 10'($urandom_range(0, 639)); fire_y0 = 10'($urandom_range(0, 479));
         fire_x1 = 10'($urandom_range(0, 639)); fire_y1 = 10'($urandom_range(0, 479));
         k = int'($urandom_range(0, N-1));
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, 2'($urandom), kl,
               m_x[k] + int'($urandom_range(0, 8)) - 1, m_y[k] + int'($urandom_range(0, 8)) - 1);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
